seq_div8: RTL and testbench

Sequential restoring divider that computes the unsigned quotient and remainder of two WIDTH-bit operands, one quotient bit per clock. It is the inverse datapath of the 8-bit (approximate) multiplier and is used to check multiplier products (product / operand == other operand) and to build ratio logic alongside it. When the approximate mode is compiled in, it skips the low quotient bits, matching the multiplier's accuracy-for-latency trade.

---
 rtl/div_pkg.sv | 28 ++
 rtl/div_step.sv | 38 +++
 rtl/seq_div8.sv | 119 +++++++++++
 tb/tb_seq_div8.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider: FSM states,
// counter sizing and the single-bit subtractor cell.
package div_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(DIV_WIDTH);

  // Full subtractor: returns {borrow_out, difference}.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bin);
    logic d;
    logic bout;
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
    return {bout, d};
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring step: t = {r, in_bit}; subtract divisor when t >= divisor.
// The difference comes from a ripple chain of full-subtractor cells.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);
  logic [WIDTH:0]   t_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH:0]   borrow_s;

  assign t_s         = {r, in_bit};
  assign borrow_s[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign {borrow_s[i+1], diff_s[i]} = full_sub(t_s[i], divisor[i], borrow_s[i]);
  end

  // Top cell has a zero subtrahend bit, so only its borrow matters.
  assign q_bit = t_s[WIDTH] | ~borrow_s[WIDTH];

  // Restore: keep t when the subtraction would go negative.
  always_comb begin
    r_next = t_s[WIDTH-1:0];
    if (q_bit) begin
      r_next = diff_s;
    end else begin
      r_next = t_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/seq_div8.sv
// seq_div8: sequential restoring divider, one quotient bit per clock.
// Define APPROX_DIV_EN to skip the low APPROX_BITS quotient bits (remainder forced to 0).
module seq_div8
  import div_pkg::*;
#(
  parameter int WIDTH       = DIV_WIDTH,
  parameter int APPROX_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = (WIDTH == DIV_WIDTH) ? CNT_W : cnt_width(WIDTH);
`ifdef APPROX_DIV_EN
  localparam int N_STEPS  = WIDTH - APPROX_BITS;
  localparam int Q_SHIFT  = APPROX_BITS;
  localparam bit KEEP_REM = 1'b0;
`else
  localparam int N_STEPS  = WIDTH;
  localparam int Q_SHIFT  = 0 * APPROX_BITS;
  localparam bit KEEP_REM = 1'b1;
`endif
  localparam logic [CW-1:0] CNT_LOAD = CW'(N_STEPS);
  localparam logic [CW-1:0] CNT_LAST = CW'(32'd1);

  div_state_e       state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] step_rem_s;
  logic             step_q_s;
  logic [WIDTH-1:0] final_q_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r       (rem_r),
    .in_bit  (dvd_r[WIDTH-1]),
    .divisor (dvs_r),
    .r_next  (step_rem_s),
    .q_bit   (step_q_s)
  );

  // Final quotient includes this cycle's bit; skipped low bits land as zeros.
  assign final_q_s = {quo_r[WIDTH-2:0], step_q_s} << Q_SHIFT;

  // FSM, datapath shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      dvd_r       <= {WIDTH{1'b0}};
      dvs_r       <= {WIDTH{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      quo_r       <= {WIDTH{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= {WIDTH{1'b0}};
      remainder   <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dvd_r       <= dividend;
            dvs_r       <= divisor;
            rem_r       <= {WIDTH{1'b0}};
            quo_r       <= {WIDTH{1'b0}};
            cnt_r       <= CNT_LOAD;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            if (divisor == {WIDTH{1'b0}}) begin
              state_r     <= DONE;
              done        <= 1'b1;
              quotient    <= {WIDTH{1'b1}};
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state_r <= RUN;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          rem_r <= step_rem_s;
          quo_r <= {quo_r[WIDTH-2:0], step_q_s};
          dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
          cnt_r <= cnt_r - CNT_LAST;
          if (cnt_r == CNT_LAST) begin
            state_r   <= DONE;
            done      <= 1'b1;
            quotient  <= final_q_s;
            remainder <= KEEP_REM ? step_rem_s : {WIDTH{1'b0}};
          end
        end
        DONE: begin
          state_r <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div8.sv
// Self-checking bench for seq_div8: arithmetic reference model compared every cycle,
// plus directed divisions with hand-computed results.
`timescale 1ns/1ps
module tb_seq_div8;
`ifdef APPROX_DIV_EN
  localparam int  N_EXP    = 6;
  localparam int  DONE_CYC = 7;
  localparam bit  APPROX   = 1'b1;
`else
  localparam int  N_EXP    = 8;
  localparam int  DONE_CYC = 9;
  localparam bit  APPROX   = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'd0;
  logic [7:0] divisor = 8'd0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // reference model state
  bit       m_busy = 1'b0, m_done = 1'b0, m_z = 1'b0;
  int       m_left = 0;
  int       m_q = 0, m_r = 0, p_q = 0, p_r = 0;

  seq_div8 #(.WIDTH(8), .APPROX_BITS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: latency from operation count, results from plain arithmetic.
  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_z = 1'b0; m_left = 0; m_q = 0; m_r = 0;
    end else begin
      m_done = 1'b0;
      if (m_left != 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1; m_q = p_q; m_r = p_r;
        end
      end else if (m_busy) begin
        m_busy = 1'b0;
      end else if (start) begin
        m_busy = 1'b1;
        m_z    = 1'b0;
        if (divisor == 8'd0) begin
          m_done = 1'b1; m_q = 255; m_r = int'(dividend); m_z = 1'b1;
        end else begin
          p_q = int'(dividend) / int'(divisor);
          p_r = int'(dividend) % int'(divisor);
          if (APPROX) begin
            p_q = p_q & ~3;
            p_r = 0;
          end
          m_left = N_EXP;
        end
      end
    end
  end

  // Compare DUT against the model on every cycle after reset.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", int'(busy), int'(m_busy));
      check("done", int'(done), int'(m_done));
      check("quotient", int'(quotient), m_q);
      check("remainder", int'(remainder), m_r);
      check("div_by_zero", int'(div_by_zero), int'(m_z));
    end
  end

  // One division with literal expectations; optional start pulse while busy at cycle inj.
  task automatic do_div(input logic [7:0] a, input logic [7:0] b,
                        input int eq, input int er, input int ez,
                        input int aq, input int exp_cyc, input int inj, input string nm);
    int ndone = 0;
    int dcyc = -1;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (inj != 0 && c == inj) begin
        start = 1'b1; dividend = 8'd9; divisor = 8'd3;
      end
      if (inj != 0 && c == inj + 1) start = 1'b0;
      if (done) begin ndone++; dcyc = c; end
      if (!busy && ndone > 0) break;
    end
    if (ndone == 0) check({nm, "_timeout"}, 0, 1);
    check({nm, "_ndone"}, ndone, 1);
    check({nm, "_cycle"}, dcyc, exp_cyc);
    check({nm, "_q"}, int'(quotient), APPROX ? aq : eq);
    check({nm, "_r"}, int'(remainder), (APPROX && ez == 0) ? 0 : er);
    check({nm, "_z"}, int'(div_by_zero), ez);
  endtask

  initial begin
    int nd;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_q", int'(quotient), 0);
    check("rst_r", int'(remainder), 0);
    check("rst_z", int'(div_by_zero), 0);
    rst = 1'b0;

    do_div(8'd200, 8'd7,   28, 4, 0,  28, DONE_CYC, 0, "d200_7");
    do_div(8'd5,   8'd0,  255, 5, 1, 255, 1,        0, "d5_0");
    do_div(8'd10,  8'd2,    5, 0, 0,   4, DONE_CYC, 0, "d10_2");
    do_div(8'd255, 8'd1,  255, 0, 0, 252, DONE_CYC, 0, "d255_1");
    do_div(8'd3,   8'd10,   0, 3, 0,   0, DONE_CYC, 0, "d3_10");
    do_div(8'd255, 8'd255,  1, 0, 0,   0, DONE_CYC, 0, "d255_255");
    do_div(8'd200, 8'd7,   28, 4, 0,  28, DONE_CYC, 4, "busy_start");

    // Reset in cycle 5 of a run.
    @(negedge clk);
    dividend = 8'd200; divisor = 8'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_q", int'(quotient), 0);
    check("midrst_r", int'(remainder), 0);
    check("midrst_z", int'(div_by_zero), 0);
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) nd++;
      @(negedge clk);
    end
    check("midrst_nodone", nd, 0);
    do_div(8'd100, 8'd7, 14, 2, 0, 12, DONE_CYC, 0, "d100_7");

    // Start held high: back-to-back divisions, one per N+2 cycles.
    dividend = 8'd50; divisor = 8'd6; start = 1'b1;
    nd = 0;
    for (int c = 1; c <= 2 * N_EXP + 5; c++) begin
      @(negedge clk);
      if (c == N_EXP + 3) start = 1'b0;
      if (done) nd++;
    end
    check("held_ndone", nd, 2);
    check("held_q", int'(quotient), 8);
    check("held_r", int'(remainder), APPROX ? 0 : 2);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
